port_display_ctrl: RTL and testbench



---
 rtl/port_display_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_port_display_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/port_display_ctrl.sv
// Captures CPU output-port writes, converts each value to BCD with one shared
// double-dabble engine, and drives active-low 7-segment digits per display mode.
module port_display_ctrl #(
   parameter int NUM_PORTS       = 8,
   parameter int DATA_W          = 16,
   parameter int NUM_DIGITS      = 6,
   parameter int NUM_MODES       = 3,
   parameter logic [NUM_MODES*NUM_DIGITS*8-1:0] DIGIT_MAP = {
      8'h21, 8'h20, 8'h11, 8'h10, 8'h01, 8'h00,   // mode2 hhmmss
      8'h51, 8'h50, 8'h41, 8'h40, 8'h31, 8'h30,   // mode1 yymmdd
      8'h53, 8'h52, 8'h51, 8'h50, 8'h41, 8'h40},  // mode0 yyyymm
   parameter int RESET_MODE      = 2,
   parameter int DEBOUNCE_CYCLES = 100000,
   localparam int MODE_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    write_out,
   input  logic [3:0]              out_port,
   input  logic [DATA_W-1:0]       out_data,
   input  logic [NUM_MODES-1:0]    mode_btn,
   output logic [MODE_W-1:0]       mode,
   output logic                    busy,
   output logic [NUM_DIGITS*7-1:0] seg
);

   localparam int NBCD   = (DATA_W * 30103 + 99999) / 100000;  // ceil(DATA_W*log10(2))
   localparam int BCD_W  = 4 * NBCD;
   localparam int SH_W   = BCD_W + DATA_W;
   localparam int PIDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int POS_W  = (NBCD > 1) ? $clog2(NBCD) : 1;
   localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int STEP_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_COMMIT} state_t;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'd0:    glyph = 7'b1000000;
         4'd1:    glyph = 7'b1111001;
         4'd2:    glyph = 7'b0100100;
         4'd3:    glyph = 7'b0110000;
         4'd4:    glyph = 7'b0011001;
         4'd5:    glyph = 7'b0010010;
         4'd6:    glyph = 7'b0000010;
         4'd7:    glyph = 7'b1111000;
         4'd8:    glyph = 7'b0000000;
         4'd9:    glyph = 7'b0010000;
         default: glyph = 7'b0000110;
      endcase
   endfunction

   function automatic logic [NUM_DIGITS*7-1:0] reset_glyphs();
      logic [NUM_DIGITS*7-1:0] r;
      r = '0;
      for (int d = 0; d < NUM_DIGITS; d++)
         r[7*d +: 7] = (DIGIT_MAP[(RESET_MODE*NUM_DIGITS + d)*8 + 4 +: 4] == 4'hF)
                       ? 7'b1111111 : 7'b1000000;
      return r;
   endfunction

   localparam logic [NUM_DIGITS*7-1:0] SEG_RST = reset_glyphs();

   function automatic logic [SH_W-1:0] dabble(input logic [SH_W-1:0] s);
      logic [SH_W-1:0] t;
      t = s;
      for (int k = 0; k < NBCD; k++)
         if (t[DATA_W + 4*k +: 4] >= 4'd5)
            t[DATA_W + 4*k +: 4] = t[DATA_W + 4*k +: 4] + 4'd3;
      return t << 1;
   endfunction

   logic [DATA_W-1:0]    value [NUM_PORTS];
   logic [3:0]           cache [NUM_PORTS][NBCD];
   logic [NUM_PORTS-1:0] pending, pending_next;
   state_t               state, state_next;
   logic [SH_W-1:0]      shreg;
   logic [STEP_W-1:0]    step_cnt;
   logic [PIDX_W-1:0]    sel, pick, widx;
   logic                 wr_hit, take;

   assign wr_hit = write_out && (int'(out_port) < NUM_PORTS);
   assign widx   = out_port[PIDX_W-1:0];

   always_comb begin
      pick = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--)
         if (pending[i]) pick = PIDX_W'(i);
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   if (|pending) state_next = S_LOAD;
         S_LOAD:   state_next = S_SHIFT;
         S_SHIFT:  if (step_cnt == STEP_W'(DATA_W - 1)) state_next = S_COMMIT;
         S_COMMIT: state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy = (state != S_IDLE) || (|pending);
      take = (state == S_IDLE) && (|pending);
   end

   // A write landing on the port just taken by IDLE leaves its pending bit set.
   always_comb begin
      pending_next = pending;
      if (take)   pending_next[pick] = 1'b0;
      if (wr_hit) pending_next[widx] = 1'b1;
   end

   // NOTE: value and cache are small register files with a defined reset
   // value, so they are reset explicitly rather than left to RAM inference.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending  <= '0;
         shreg    <= '0;
         step_cnt <= '0;
         sel      <= '0;
         for (int i = 0; i < NUM_PORTS; i++) begin
            value[i] <= '0;
            for (int k = 0; k < NBCD; k++) cache[i][k] <= '0;
         end
      end else begin
         pending <= pending_next;
         if (wr_hit) value[widx] <= out_data;
         if (take) begin
            sel   <= pick;
            shreg <= {BCD_W'(0), value[pick]};
         end
         // LOAD performs the first dabble step so a commit lands DATA_W+2 edges after the write.
         if (state == S_LOAD) begin
            shreg    <= dabble(shreg);
            step_cnt <= STEP_W'(1);
         end
         if (state == S_SHIFT) begin
            shreg    <= dabble(shreg);
            step_cnt <= step_cnt + STEP_W'(1);
         end
         if (state == S_COMMIT)
            for (int k = 0; k < NBCD; k++) cache[sel][k] <= shreg[DATA_W + 4*k +: 4];
      end
   end

   logic [NUM_MODES-1:0] sync1, sync2, level, level_d, press;
   logic [CNT_W-1:0]     db_cnt [NUM_MODES];
   logic [MODE_W-1:0]    press_idx;
   logic                 press_any;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1   <= '0;
         sync2   <= '0;
         level   <= '0;
         level_d <= '0;
         for (int b = 0; b < NUM_MODES; b++) db_cnt[b] <= '0;
      end else begin
         sync1   <= mode_btn;
         sync2   <= sync1;
         level_d <= level;
         for (int b = 0; b < NUM_MODES; b++) begin
            if (sync2[b] != level[b]) begin
               if (db_cnt[b] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                  level[b]  <= sync2[b];
                  db_cnt[b] <= '0;
               end else begin
                  db_cnt[b] <= db_cnt[b] + CNT_W'(1);
               end
            end else begin
               db_cnt[b] <= '0;
            end
         end
      end
   end

   assign press = level & ~level_d;

   always_comb begin
      press_idx = '0;
      press_any = 1'b0;
      for (int b = NUM_MODES - 1; b >= 0; b--)
         if (press[b]) begin
            press_idx = MODE_W'(b);
            press_any = 1'b1;
         end
   end

   always_ff @(posedge clk) begin
      if (reset)          mode <= MODE_W'(RESET_MODE);
      else if (press_any) mode <= press_idx;
   end

   logic [NUM_DIGITS*7-1:0] seg_next;
   logic [7:0]              entry;
   logic [3:0]              nib;

   always_comb begin
      seg_next = '1;
      entry    = 8'hF0;
      nib      = '0;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         entry = 8'hF0;
         nib   = '0;
         if (int'(mode) < NUM_MODES)
            entry = DIGIT_MAP[(int'(mode)*NUM_DIGITS + d)*8 +: 8];
         if (entry[7:4] != 4'hF) begin
            if ((int'(entry[7:4]) < NUM_PORTS) && (int'(entry[3:0]) < NBCD))
               nib = cache[entry[4 +: PIDX_W]][entry[0 +: POS_W]];
            seg_next[7*d +: 7] = glyph(nib);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) seg <= SEG_RST;
      else       seg <= seg_next;
   end

endmodule

// File: tb/tb_port_display_ctrl.sv
// Directed bench for port_display_ctrl: capture, conversion timing, mode buttons,
// digit-map boundaries and synchronous reset; inputs and samples on the falling edge.
module tb_port_display_ctrl;

   localparam int DEB = 16;
   localparam logic [4*6*8-1:0] MAP = {
      8'hF0, 8'h95, 8'h07, 8'h02, 8'h04, 8'h00,   // mode3: blank, bad port, bad pos, p0.2, p0.4, p0.0
      8'h21, 8'h20, 8'h11, 8'h10, 8'h01, 8'h00,
      8'h51, 8'h50, 8'h41, 8'h40, 8'h31, 8'h30,
      8'h53, 8'h52, 8'h51, 8'h50, 8'h41, 8'h40};

   logic        clk = 1'b0;
   logic        reset;
   logic        write_out;
   logic [3:0]  out_port;
   logic [15:0] out_data;
   logic [3:0]  mode_btn;
   logic [1:0]  mode;
   logic        busy;
   logic [41:0] seg;

   int n_checks = 0;
   int n_fail   = 0;

   port_display_ctrl #(
      .NUM_PORTS(8), .DATA_W(16), .NUM_DIGITS(6), .NUM_MODES(4),
      .DIGIT_MAP(MAP), .RESET_MODE(2), .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk), .reset(reset), .write_out(write_out), .out_port(out_port),
      .out_data(out_data), .mode_btn(mode_btn), .mode(mode), .busy(busy), .seg(seg)
   );

   always #5 clk = ~clk;

   function automatic logic [6:0] glyph(input int n);
      case (n)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   function automatic logic [41:0] segs(input int d5, d4, d3, d2, d1, d0);
      return {glyph(d5), glyph(d4), glyph(d3), glyph(d2), glyph(d1), glyph(d0)};
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic start_write(input logic [3:0] p, input logic [15:0] v);
      write_out = 1'b1;
      out_port  = p;
      out_data  = v;
   endtask

   task automatic press(input logic [3:0] b);
      mode_btn = b;
      repeat (DEB + 3) tick();
      mode_btn = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0;
      repeat (5) tick();
      n_checks++;
      if (mode !== 2'd2) begin n_fail++; $display("FAIL reset_mode: got %0d expected 2", mode); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_checks++;
      if (seg !== segs(0, 0, 0, 0, 0, 0))
         begin n_fail++; $display("FAIL reset_seg: got %h expected %h", seg, segs(0, 0, 0, 0, 0, 0)); end
   endtask

   task automatic test_single_write();
      start_write(4'd0, 16'd59);
      tick();                       // t+0.5
      write_out = 1'b0;
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_start: got %b expected 1", busy); end
      repeat (17) tick();           // t+17.5
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_t17: got %b expected 1", busy); end
      tick();                       // t+18.5
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_t18: got %b expected 0", busy); end
      n_checks++;
      if (seg !== segs(0, 0, 0, 0, 0, 0))
         begin n_fail++; $display("FAIL single_seg_early: got %h expected %h", seg, segs(0, 0, 0, 0, 0, 0)); end
      tick();                       // t+19.5
      n_checks++;
      if (seg[13:7] !== 7'b0010010) begin n_fail++; $display("FAIL single_d1: got %b expected 0010010", seg[13:7]); end
      n_checks++;
      if (seg[6:0] !== 7'b0010000) begin n_fail++; $display("FAIL single_d0: got %b expected 0010000", seg[6:0]); end
   endtask

   task automatic test_mode0();
      start_write(4'd5, 16'd2023);
      mode_btn = 4'b0001;
      tick();                       // t+0.5
      start_write(4'd4, 16'd7);
      tick();                       // t+1.5
      write_out = 1'b0;
      for (int i = 0; i < 19; i++) begin
         tick();                    // t+2.5+i
         if (i == 16) mode_btn = '0;
      end                           // t+20.5
      n_checks++;
      if (mode !== 2'd0) begin n_fail++; $display("FAIL mode0_mode: got %0d expected 0", mode); end
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL mode0_busy_mid: got %b expected 1", busy); end
      n_checks++;
      if (seg !== segs(2, 0, 2, 3, 0, 0))
         begin n_fail++; $display("FAIL mode0_p5_first: got %h expected %h", seg, segs(2, 0, 2, 3, 0, 0)); end
      repeat (20) tick();           // t+40.5
      n_checks++;
      if (seg !== segs(2, 0, 2, 3, 0, 7))
         begin n_fail++; $display("FAIL mode0_final: got %h expected %h", seg, segs(2, 0, 2, 3, 0, 7)); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mode0_busy_end: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      int busy_low;
      press(4'b0100);
      repeat (2) tick();
      n_checks++;
      if (mode !== 2'd2) begin n_fail++; $display("FAIL b2b_mode: got %0d expected 2", mode); end
      busy_low = 0;
      start_write(4'd1, 16'd12);
      tick();                       // t+0.5
      write_out = 1'b0;
      if (busy !== 1'b1) busy_low++;
      tick();                       // t+1.5
      start_write(4'd1, 16'd34);
      if (busy !== 1'b1) busy_low++;
      tick();                       // t+2.5
      write_out = 1'b0;
      if (busy !== 1'b1) busy_low++;
      for (int i = 3; i <= 35; i++) begin
         tick();                    // t+i+0.5
         if (busy !== 1'b1) busy_low++;
         if (i == 19) begin
            n_checks++;
            if (seg !== segs(0, 0, 1, 2, 5, 9))
               begin n_fail++; $display("FAIL b2b_first: got %h expected %h", seg, segs(0, 0, 1, 2, 5, 9)); end
         end
      end
      n_checks++;
      if (busy_low !== 0) begin n_fail++; $display("FAIL b2b_busy_held: got %0d idle samples expected 0", busy_low); end
      tick();                       // t+36.5
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
      tick();                       // t+37.5
      n_checks++;
      if (seg !== segs(0, 0, 3, 4, 5, 9))
         begin n_fail++; $display("FAIL b2b_final: got %h expected %h", seg, segs(0, 0, 3, 4, 5, 9)); end
   endtask

   task automatic test_boundary();
      logic [3:0] bad_ports [2];
      bad_ports[0] = 4'd8;
      bad_ports[1] = 4'd12;
      press(4'b1000);
      repeat (2) tick();
      n_checks++;
      if (mode !== 2'd3) begin n_fail++; $display("FAIL map_mode: got %0d expected 3", mode); end
      n_checks++;
      if (seg !== segs(-1, 0, 0, 0, 0, 9))
         begin n_fail++; $display("FAIL map_p59: got %h expected %h", seg, segs(-1, 0, 0, 0, 0, 9)); end
      start_write(4'd0, 16'd65535);
      tick();
      write_out = 1'b0;
      repeat (25) tick();
      n_checks++;
      if (seg !== segs(-1, 0, 0, 5, 6, 5))
         begin n_fail++; $display("FAIL map_max: got %h expected %h", seg, segs(-1, 0, 0, 5, 6, 5)); end
      for (int i = 0; i < 2; i++) begin
         start_write(bad_ports[i], 16'd1234);
         tick();
         write_out = 1'b0;
         n_checks++;
         if (busy !== 1'b0)
            begin n_fail++; $display("FAIL bad_port_%0d_busy: got %b expected 0", bad_ports[i], busy); end
      end
      repeat (25) tick();
      n_checks++;
      if (seg !== segs(-1, 0, 0, 5, 6, 5))
         begin n_fail++; $display("FAIL bad_port_seg: got %h expected %h", seg, segs(-1, 0, 0, 5, 6, 5)); end
   endtask

   task automatic test_bounce();
      for (int k = 0; k < 5; k++) begin
         mode_btn = (k % 2 == 0) ? 4'b0010 : 4'b0000;
         repeat (10) tick();
      end
      mode_btn = '0;
      repeat (DEB + 5) tick();
      n_checks++;
      if (mode !== 2'd3) begin n_fail++; $display("FAIL bounce_mode: got %0d expected 3", mode); end
   endtask

   task automatic test_simultaneous();
      press(4'b0011);
      tick();
      n_checks++;
      if (mode !== 2'd0) begin n_fail++; $display("FAIL simul_mode: got %0d expected 0", mode); end
      repeat (DEB + 5) tick();
   endtask

   task automatic test_reset_mid();
      start_write(4'd2, 16'd23);
      tick();                       // t+0.5
      write_out = 1'b0;
      repeat (5) tick();            // t+5.5, engine in SHIFT
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
      reset = 1'b1;
      tick();                       // reset edge passed
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
      n_checks++;
      if (mode !== 2'd2) begin n_fail++; $display("FAIL rmid_mode: got %0d expected 2", mode); end
      n_checks++;
      if (seg !== segs(0, 0, 0, 0, 0, 0))
         begin n_fail++; $display("FAIL rmid_seg: got %h expected %h", seg, segs(0, 0, 0, 0, 0, 0)); end
      reset = 1'b0;
      repeat (25) tick();
      n_checks++;
      if (seg !== segs(0, 0, 0, 0, 0, 0))
         begin n_fail++; $display("FAIL rmid_cache: got %h expected %h", seg, segs(0, 0, 0, 0, 0, 0)); end
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy_late: got %b expected 0", busy); end
   endtask

   initial begin
      reset     = 1'b1;
      write_out = 1'b0;
      out_port  = '0;
      out_data  = '0;
      mode_btn  = '0;
      tick();
      test_reset();
      test_single_write();
      test_mode0();
      test_back_to_back();
      test_boundary();
      test_bounce();
      test_simultaneous();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
